// File: rtl/lsu_ctrl.sv
// Load/store unit controller for the DTCM.
// Issues one SRAM access per accepted command. Load results come back
// through a small in-order response FIFO, which sends each result either
// to the AGU or to the long-pipe writeback port.
module lsu_ctrl #(
    parameter int unsigned AW    = 16,
    parameter int unsigned DW    = 32,
    parameter int unsigned ITAGW = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               agu_cmd_valid,
    output logic               agu_cmd_ready,
    input  logic [AW-1:0]      agu_cmd_addr,
    input  logic               agu_cmd_read,
    input  logic [ITAGW-1:0]   agu_cmd_itag,
    input  logic [DW-1:0]      agu_cmd_wdata,
    input  logic [DW/8-1:0]    agu_cmd_wmask,
    input  logic               agu_cmd_back2agu,

    output logic               agu_rsp_valid,
    input  logic               agu_rsp_ready,
    output logic [DW-1:0]      agu_rsp_rdata,

    output logic               lsu_wbck_valid,
    input  logic               lsu_wbck_ready,
    output logic [DW-1:0]      lsu_wbck_data,
    output logic [ITAGW-1:0]   lsu_wbck_itag,

    output logic               ram_cs,
    output logic               ram_we,
    output logic [AW-3:0]      ram_addr,
    output logic [DW/8-1:0]    ram_wem,
    output logic [DW-1:0]      ram_din,
    input  logic [DW-1:0]      ram_dout
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);
    localparam logic [PW-1:0] LastP  = PW'(DEPTH - 1);

    // Credit count: loads accepted but not yet handed out (SRAM stage + FIFO).
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    fifo_cnt_q;
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;

    logic [DW-1:0]    fifo_data_q [DEPTH];
    logic [ITAGW-1:0] fifo_itag_q [DEPTH];
    logic             fifo_b2a_q  [DEPTH];

    // A load sits in the SRAM stage for one cycle before its data is pushed.
    logic             pend_q;
    logic [ITAGW-1:0] pend_itag_q;
    logic             pend_b2a_q;

    logic accept;
    logic load_acc;
    logic push;
    logic pop;
    logic head_valid;
    logic head_b2a;

    // The byte offset plays no part in a word-wide SRAM access.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^agu_cmd_addr[1:0];

    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == LastP) ? '0 : p + 1'b1;
    endfunction

    assign head_valid = (fifo_cnt_q != '0);
    assign head_b2a   = fifo_b2a_q[rptr_q];
    assign pop        = head_valid & (head_b2a ? agu_rsp_ready : lsu_wbck_ready);
    assign push       = pend_q;

    // A pop in this cycle frees a credit early, so a full queue can keep one
    // accept per cycle. Reset gates ready, so no SRAM access is issued during reset.
    assign agu_cmd_ready = rst_n & ((cnt_q < DepthC) | pop);
    assign accept        = agu_cmd_valid & agu_cmd_ready;
    assign load_acc      = accept & agu_cmd_read;

    assign ram_cs   = accept;
    assign ram_we   = ~agu_cmd_read;
    assign ram_addr = agu_cmd_addr[AW-1:2];
    assign ram_din  = agu_cmd_wdata;
    assign ram_wem  = agu_cmd_read ? '0 : agu_cmd_wmask;

    // Exactly one channel sees the head. Data is zeroed when that channel is not valid.
    assign agu_rsp_valid  = head_valid & head_b2a;
    assign agu_rsp_rdata  = agu_rsp_valid ? fifo_data_q[rptr_q] : '0;
    assign lsu_wbck_valid = head_valid & ~head_b2a;
    assign lsu_wbck_data  = lsu_wbck_valid ? fifo_data_q[rptr_q] : '0;
    assign lsu_wbck_itag  = lsu_wbck_valid ? fifo_itag_q[rptr_q] : '0;

    // Credit counter: +1 on a load accept, -1 on a pop, unchanged if both occur.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_acc && !pop) begin
            cnt_q <= cnt_q + 1'b1;
        end else if (pop && !load_acc) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // SRAM-stage tracking: remember the tag and route of a load issued this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= 1'b0;
            pend_itag_q <= '0;
            pend_b2a_q  <= 1'b0;
        end else begin
            pend_q <= load_acc;
            if (load_acc) begin
                pend_itag_q <= agu_cmd_itag;
                pend_b2a_q  <= agu_cmd_back2agu;
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wptr_q <= inc_ptr(wptr_q);
            if (pop)  rptr_q <= inc_ptr(rptr_q);
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + 1'b1;
            end else if (pop && !push) begin
                fifo_cnt_q <= fifo_cnt_q - 1'b1;
            end
        end
    end

    // FIFO storage: capture the raw SRAM word one cycle after the load was issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_itag_q[i] <= '0;
                fifo_b2a_q[i]  <= 1'b0;
            end
        end else if (push) begin
            fifo_data_q[wptr_q] <= ram_dout;
            fifo_itag_q[wptr_q] <= pend_itag_q;
            fifo_b2a_q[wptr_q]  <= pend_b2a_q;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl. It holds a behavioural model: a queue of outstanding
// loads, each tagged with the cycle its data becomes visible. The model is
// checked against the DUT every cycle, and directed literal checks pin the
// model's expectations.
module tb_lsu_ctrl;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int ITAGW = 1;
    localparam int DEPTH = 2;

    logic            clk;
    logic            rst_n;
    logic            agu_cmd_valid;
    logic            agu_cmd_ready;
    logic [AW-1:0]   agu_cmd_addr;
    logic            agu_cmd_read;
    logic [ITAGW-1:0] agu_cmd_itag;
    logic [DW-1:0]   agu_cmd_wdata;
    logic [DW/8-1:0] agu_cmd_wmask;
    logic            agu_cmd_back2agu;
    logic            agu_rsp_valid;
    logic            agu_rsp_ready;
    logic [DW-1:0]   agu_rsp_rdata;
    logic            lsu_wbck_valid;
    logic            lsu_wbck_ready;
    logic [DW-1:0]   lsu_wbck_data;
    logic [ITAGW-1:0] lsu_wbck_itag;
    logic            ram_cs;
    logic            ram_we;
    logic [AW-3:0]   ram_addr;
    logic [DW/8-1:0] ram_wem;
    logic [DW-1:0]   ram_din;
    logic [DW-1:0]   ram_dout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    lsu_ctrl #(.AW(AW), .DW(DW), .ITAGW(ITAGW), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .agu_cmd_valid    (agu_cmd_valid),
        .agu_cmd_ready    (agu_cmd_ready),
        .agu_cmd_addr     (agu_cmd_addr),
        .agu_cmd_read     (agu_cmd_read),
        .agu_cmd_itag     (agu_cmd_itag),
        .agu_cmd_wdata    (agu_cmd_wdata),
        .agu_cmd_wmask    (agu_cmd_wmask),
        .agu_cmd_back2agu (agu_cmd_back2agu),
        .agu_rsp_valid    (agu_rsp_valid),
        .agu_rsp_ready    (agu_rsp_ready),
        .agu_rsp_rdata    (agu_rsp_rdata),
        .lsu_wbck_valid   (lsu_wbck_valid),
        .lsu_wbck_ready   (lsu_wbck_ready),
        .lsu_wbck_data    (lsu_wbck_data),
        .lsu_wbck_itag    (lsu_wbck_itag),
        .ram_cs           (ram_cs),
        .ram_we           (ram_we),
        .ram_addr         (ram_addr),
        .ram_wem          (ram_wem),
        .ram_din          (ram_din),
        .ram_dout         (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM attached to the DUT: one-cycle read latency, byte-masked writes.
    logic [DW-1:0] sram [1 << (AW-2)];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < DW/8; b++)
                    if (ram_wem[b]) sram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
            end else begin
                ram_dout <= sram[ram_addr];
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    // Model state: the memory as the command stream defines it, and the outstanding loads.
    typedef struct {
        int              vis;
        logic [DW-1:0]   data;
        logic [ITAGW-1:0] itag;
        logic            b2a;
    } ent_t;

    logic [DW-1:0] mmem [1 << (AW-2)];
    ent_t          q[$];
    ent_t          h;
    ent_t          e;
    logic          hv;
    logic          m_pop;
    logic          m_rdy;
    logic          m_acc;
    logic [AW-3:0] idx;

    // Compare process: checks every cycle, then advances the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            chk("rst_cmd_ready", agu_cmd_ready, 0);
            chk("rst_ram_cs", ram_cs, 0);
            chk("rst_rsp_valid", agu_rsp_valid, 0);
            chk("rst_wbck_valid", lsu_wbck_valid, 0);
            chk("rst_rsp_rdata", agu_rsp_rdata, 0);
            chk("rst_wbck_data", lsu_wbck_data, 0);
        end else begin
            hv = (q.size() > 0) && (q[0].vis <= cyc);
            h  = hv ? q[0] : '{0, '0, '0, 1'b0};
            m_pop = hv && (h.b2a ? agu_rsp_ready : lsu_wbck_ready);
            m_rdy = (q.size() < DEPTH) || m_pop;
            m_acc = agu_cmd_valid && m_rdy;
            chk("cmd_ready", agu_cmd_ready, m_rdy);
            chk("ram_cs", ram_cs, m_acc);
            if (m_acc) begin
                chk("ram_we", ram_we, !agu_cmd_read);
                chk("ram_addr", ram_addr, agu_cmd_addr >> 2);
                chk("ram_wem", ram_wem, agu_cmd_read ? 0 : agu_cmd_wmask);
                chk("ram_din", ram_din, agu_cmd_wdata);
            end
            chk("rsp_valid", agu_rsp_valid, hv && h.b2a);
            chk("rsp_rdata", agu_rsp_rdata, (hv && h.b2a) ? h.data : 0);
            chk("wbck_valid", lsu_wbck_valid, hv && !h.b2a);
            chk("wbck_data", lsu_wbck_data, (hv && !h.b2a) ? h.data : 0);
            chk("wbck_itag", lsu_wbck_itag, (hv && !h.b2a) ? h.itag : 0);
            if (m_pop) void'(q.pop_front());
            if (m_acc) begin
                idx = agu_cmd_addr[AW-1:2];
                if (agu_cmd_read) begin
                    e.vis  = cyc + 2;
                    e.data = mmem[idx];
                    e.itag = agu_cmd_itag;
                    e.b2a  = agu_cmd_back2agu;
                    q.push_back(e);
                end else begin
                    for (int b = 0; b < DW/8; b++)
                        if (agu_cmd_wmask[b]) mmem[idx][8*b +: 8] = agu_cmd_wdata[8*b +: 8];
                end
            end
        end
        cyc++;
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [DW/8-1:0] wm, input logic [ITAGW-1:0] it, input logic b2a);
        agu_cmd_valid    = 1'b1;
        agu_cmd_read     = rd;
        agu_cmd_addr     = a;
        agu_cmd_wdata    = wd;
        agu_cmd_wmask    = wm;
        agu_cmd_itag     = it;
        agu_cmd_back2agu = b2a;
    endtask

    task automatic idle();
        agu_cmd_valid = 1'b0;
        agu_cmd_read  = 1'b0;
        agu_cmd_addr  = '0;
        agu_cmd_wdata = '0;
        agu_cmd_wmask = '0;
        agu_cmd_itag  = '0;
        agu_cmd_back2agu = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1 << (AW-2)); i++) begin
            sram[i] = 32'hC0DE_0000 | i;
            mmem[i] = 32'hC0DE_0000 | i;
        end
        ram_dout = '0;
        idle();
        agu_rsp_ready  = 1'b1;
        lsu_wbck_ready = 1'b1;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("lit_reset_ready", agu_cmd_ready, 0);
        chk("lit_reset_wbck_data", lsu_wbck_data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Store: same-cycle SRAM drive, no response.
        cmd(1'b0, 16'h0010, 32'h1122_3344, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        chk("lit_st_cs", ram_cs, 1);
        chk("lit_st_we", ram_we, 1);
        chk("lit_st_addr", ram_addr, 14'h0004);
        chk("lit_st_wem", ram_wem, 4'hF);
        // Load of the stored word, to writeback with itag 1.
        next(); cmd(1'b1, 16'h0010, 32'h0, 4'hF, 1'b1, 1'b0);
        @(negedge clk);
        chk("lit_ld_wem", ram_wem, 0);
        next(); idle();
        @(negedge clk);
        chk("lit_ld_n1_valid", lsu_wbck_valid, 0);
        next();
        @(negedge clk);
        chk("lit_ld_n2_valid", lsu_wbck_valid, 1);
        chk("lit_ld_n2_data", lsu_wbck_data, 32'h1122_3344);
        chk("lit_ld_n2_itag", lsu_wbck_itag, 1);
        chk("lit_ld_n2_rsp", agu_rsp_valid, 0);

        // Partial store, then a misaligned load of the same word back to the AGU.
        next(); cmd(1'b0, 16'h0014, 32'hAABB_CCDD, 4'h5, 1'b0, 1'b0);
        next(); cmd(1'b1, 16'h0017, 32'h0, 4'h0, 1'b0, 1'b1);
        next(); idle();
        next();
        @(negedge clk);
        chk("lit_part_valid", agu_rsp_valid, 1);
        chk("lit_part_rdata", agu_rsp_rdata, 32'hC0BB_00DD);

        // Two loads with writeback stalled; the third command must wait for credit.
        next(); lsu_wbck_ready = 1'b0; cmd(1'b1, 16'h0010, 32'h0, 4'h0, 1'b0, 1'b0);
        next(); cmd(1'b1, 16'h0014, 32'h0, 4'h0, 1'b1, 1'b0);
        next(); cmd(1'b0, 16'h0020, 32'h5555_AAAA, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        chk("lit_full_ready", agu_cmd_ready, 0);
        chk("lit_full_cs", ram_cs, 0);
        next();
        next();
        @(negedge clk);
        chk("lit_full_ready2", agu_cmd_ready, 0);
        next(); lsu_wbck_ready = 1'b1;
        @(negedge clk);
        chk("lit_pop_ready", agu_cmd_ready, 1);
        chk("lit_pop_data0", lsu_wbck_data, 32'h1122_3344);
        next(); idle();
        @(negedge clk);
        chk("lit_pop_data1", lsu_wbck_data, 32'hC0BB_00DD);
        chk("lit_pop_itag1", lsu_wbck_itag, 1);

        // Head to AGU stalled: the writeback entry behind it is withheld.
        next(); agu_rsp_ready = 1'b0; cmd(1'b1, 16'h0010, 32'h0, 4'h0, 1'b0, 1'b1);
        next(); cmd(1'b1, 16'h0024, 32'h0, 4'h0, 1'b1, 1'b0);
        next(); idle();
        next();
        next();
        @(negedge clk);
        chk("lit_hol_rsp", agu_rsp_valid, 1);
        chk("lit_hol_wbck", lsu_wbck_valid, 0);
        next(); agu_rsp_ready = 1'b1;
        @(negedge clk);
        chk("lit_hol_a", agu_rsp_rdata, 32'h1122_3344);
        next();
        @(negedge clk);
        chk("lit_hol_b_valid", lsu_wbck_valid, 1);
        chk("lit_hol_b_data", lsu_wbck_data, 32'hC0DE_0009);

        // Streaming loads: one accept and one pop per cycle, pointers wrapping.
        for (int i = 0; i < 10; i++) begin
            next(); cmd(1'b1, 16'(4 * i), 32'h0, 4'h0, 1'(i), 1'(i));
            @(negedge clk);
            chk("lit_stream_ready", agu_cmd_ready, 1);
        end
        next(); idle();
        repeat (3) next();

        // Reset with queued loads: everything is discarded.
        lsu_wbck_ready = 1'b0;
        cmd(1'b1, 16'h0010, 32'h0, 4'h0, 1'b0, 1'b0);
        next(); cmd(1'b1, 16'h0014, 32'h0, 4'h0, 1'b1, 1'b0);
        next(); cmd(1'b1, 16'h0018, 32'h0, 4'h0, 1'b0, 1'b0);
        next();
        next(); rst_n = 1'b0;
        @(negedge clk);
        chk("lit_mid_rst_wbck", lsu_wbck_valid, 0);
        chk("lit_mid_rst_cs", ram_cs, 0);
        next();
        next(); rst_n = 1'b1; idle(); lsu_wbck_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("lit_post_rst_wbck", lsu_wbck_valid, 0);
            chk("lit_post_rst_rsp", agu_rsp_valid, 0);
            next();
        end

        // Mixed traffic with toggling back-pressure.
        for (int i = 0; i < 24; i++) begin
            next();
            cmd((i % 3) != 0, 16'(4 * i + i % 4), 32'hF00D_0000 | i, 4'(i), 1'(i >> 1),
                1'((i >> 1) & 1));
            agu_rsp_ready  = (i % 4) != 1;
            lsu_wbck_ready = (i % 5) != 2;
        end
        next(); idle(); agu_rsp_ready = 1'b1; lsu_wbck_ready = 1'b1;
        repeat (6) next();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
